// File: rtl/multi_channel_counter.sv
// Multi-channel edge counter over a programmable window of whole milliseconds.
// Per-channel enable mask, saturation flags, single-shot or continuous windows.
module multi_channel_counter #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CNT_W     = 32,
    parameter logic [7:0]  ADDR_BASE = 8'h20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              addr,
    input  logic [7:0]              data,
    output logic [7:0]              data_out,
    input  logic                    write,
    input  logic                    write32,
    input  logic [31:0]             data32,
    input  logic [N_CH-1:0]         count,
    input  logic                    start,
    output logic                    stop_step,
    output logic                    busy,
    output logic [31:0]             time_export,
    output logic [N_CH*CNT_W-1:0]   signals_export,
    output logic [N_CH-1:0]         ovf
);

    localparam int unsigned TICK  = CLK_FREQ / 1000;
    localparam int unsigned PRE_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0] A_CTRL = ADDR_BASE;
    localparam logic [7:0] A_MASK = ADDR_BASE + 8'd1;
    localparam logic [7:0] A_WIN  = ADDR_BASE + 8'd2;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_LATCH} state_t;

    state_t                  state_q, state_d;
    logic                    mode_q, mode_d, run_mode_q, run_mode_d;
    logic [N_CH-1:0]         mask_q, mask_d, run_mask_q, run_mask_d;
    logic [31:0]             win_q, win_d, run_win_q, run_win_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [31:0]             ms_q, ms_d;
    logic [N_CH-1:0]         sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CNT_W-1:0]        cnt_q [N_CH];
    logic [CNT_W-1:0]        cnt_d [N_CH];
    logic [N_CH-1:0]         ovf_acc_q, ovf_acc_d;
    logic [N_CH*CNT_W-1:0]   sig_q, sig_d;
    logic [N_CH-1:0]         ovf_q, ovf_d;
    logic [31:0]             time_q, time_d;
    logic                    stop_q, stop_d, busy_q, busy_d;

    logic [N_CH-1:0]         edge_pulse;
    logic [15:0]             data_ext, mask_ext;
    logic                    abort, wrap;
    logic                    unused_data;

    assign unused_data = ^data;
    assign edge_pulse  = sync2_q & ~prev_q;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        mask_d     = mask_q;
        win_d      = win_q;
        run_mode_d = run_mode_q;
        run_mask_d = run_mask_q;
        run_win_d  = run_win_q;
        pre_d      = pre_q;
        ms_d       = ms_q;
        sync1_d    = count;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        cnt_d      = cnt_q;
        ovf_acc_d  = ovf_acc_q;
        sig_d      = sig_q;
        ovf_d      = ovf_q;
        time_d     = time_q;
        stop_d     = 1'b0;
        wrap       = 1'b0;
        data_ext   = {8'h00, data};

        abort = write && (addr == A_CTRL) && data[2];
        if (write && (addr == A_CTRL)) mode_d = data[0];
        if (write && (addr == A_MASK)) mask_d = data_ext[N_CH-1:0];
        if (write32 && (addr == A_WIN)) win_d = (data32 == 32'd0) ? 32'd1 : data32;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ARM;
            end
            S_ARM: begin
                for (int unsigned i = 0; i < N_CH; i++) cnt_d[i] = '0;
                ovf_acc_d  = '0;
                pre_d      = '0;
                ms_d       = '0;
                run_win_d  = win_q;
                run_mask_d = mask_q;
                run_mode_d = mode_q;
                state_d    = S_COUNT;
            end
            S_COUNT: begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (run_mask_q[i] && edge_pulse[i]) begin
                        if (cnt_q[i] == CNT_MAX) ovf_acc_d[i] = 1'b1;
                        else                     cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                wrap  = (pre_q == PRE_LAST);
                pre_d = wrap ? '0 : pre_q + 1'b1;
                if (wrap) ms_d = ms_q + 32'd1;
                // Exports are taken from the next-state counters so the final
                // COUNT cycle's edge is included; in continuous mode the LATCH
                // cycle is folded into the following ARM.
                if (wrap && (ms_q + 32'd1 == run_win_q)) begin
                    for (int unsigned i = 0; i < N_CH; i++)
                        sig_d[i*CNT_W +: CNT_W] = cnt_d[i];
                    ovf_d   = ovf_acc_d;
                    time_d  = run_win_q;
                    stop_d  = 1'b1;
                    state_d = run_mode_q ? S_ARM : S_LATCH;
                end
            end
            S_LATCH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && ((state_q == S_ARM) || (state_q == S_COUNT))) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
            sig_d   = sig_q;
            ovf_d   = ovf_q;
            time_d  = time_q;
        end

        busy_d = (state_d == S_ARM) || (state_d == S_COUNT);
    end

    always_comb begin
        mask_ext           = '0;
        mask_ext[N_CH-1:0] = mask_q;
        case (addr)
            A_CTRL:  data_out = {5'b0, busy_q, 1'b0, mode_q};
            A_MASK:  data_out = mask_ext[7:0];
            A_WIN:   data_out = win_q[7:0];
            default: data_out = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            mask_q     <= '1;
            win_q      <= 32'd1;
            run_mode_q <= 1'b0;
            run_mask_q <= '1;
            run_win_q  <= 32'd1;
            pre_q      <= '0;
            ms_q       <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
            ovf_acc_q  <= '0;
            sig_q      <= '0;
            ovf_q      <= '0;
            time_q     <= '0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            mask_q     <= mask_d;
            win_q      <= win_d;
            run_mode_q <= run_mode_d;
            run_mask_q <= run_mask_d;
            run_win_q  <= run_win_d;
            pre_q      <= pre_d;
            ms_q       <= ms_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
            ovf_acc_q  <= ovf_acc_d;
            sig_q      <= sig_d;
            ovf_q      <= ovf_d;
            time_q     <= time_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
        end
    end

    assign stop_step      = stop_q;
    assign busy           = busy_q;
    assign time_export    = time_q;
    assign signals_export = sig_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_multi_channel_counter.sv
// Randomised bench for multi_channel_counter against a pulse-count reference model.
module tb_multi_channel_counter;

    localparam int unsigned CLK_FREQ = 10000;
    localparam int unsigned N_CH     = 4;
    localparam int unsigned CNT_W    = 8;
    localparam logic [7:0]  BASE     = 8'h20;
    localparam int unsigned TICK     = CLK_FREQ / 1000;
    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

    logic                  clk, reset, write, write32, start, stop_step, busy;
    logic [7:0]            addr, data, data_out;
    logic [31:0]           data32, time_export;
    logic [N_CH-1:0]       count, ovf;
    logic [N_CH*CNT_W-1:0] signals_export;

    multi_channel_counter #(
        .CLK_FREQ(CLK_FREQ), .N_CH(N_CH), .CNT_W(CNT_W), .ADDR_BASE(BASE)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .data(data), .data_out(data_out),
        .write(write), .write32(write32), .data32(data32), .count(count),
        .start(start), .stop_step(stop_step), .busy(busy),
        .time_export(time_export), .signals_export(signals_export), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses [3][N_CH];
    logic [3:0]  model_mask;
    int unsigned model_win;
    logic [31:0] exp_sig, exp_ovf, exp_time;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected exports: enabled channels saturate at CNT_MAX, ovf once a pulse
    // arrives beyond the saturation value; disabled channels read zero.
    function automatic void model_window(input int w);
        exp_sig = '0;
        exp_ovf = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (model_mask[c]) begin
                exp_sig[c*CNT_W +: CNT_W] = (pulses[w][c] > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                                                      : pulses[w][c][CNT_W-1:0];
                exp_ovf[c] = (pulses[w][c] > CNT_MAX);
            end
        end
        exp_time = model_win;
    endfunction

    task automatic wr8(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk); addr = a; data = d; write = 1'b1;
        @(negedge clk); write = 1'b0; addr = 8'h00;
    endtask

    task automatic wr32(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk); addr = a; data32 = d; write32 = 1'b1;
        @(negedge clk); write32 = 1'b0; addr = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a, input string tag, input logic [7:0] exp);
        @(negedge clk); addr = a;
        #1 check(tag, {24'h0, data_out}, {24'h0, exp});
        addr = 8'h00;
    endtask

    task automatic check_exports(input string tag);
        check({tag, "_sig"}, signals_export, exp_sig);
        check({tag, "_ovf"}, {28'h0, ovf}, exp_ovf);
        check({tag, "_time"}, time_export, exp_time);
    endtask

    // Starts one run and drives pulses[w] into each window; every stop_step is
    // checked for position and export contents.
    task automatic run(input int nwin, input bit cont, input string tag);
        int unsigned period, win_cycles, j, off, seen, exp_n;
        logic [N_CH-1:0] cv;
        win_cycles = model_win * TICK;
        period     = win_cycles + 1;
        seen       = 0;
        @(negedge clk); start = 1'b1;
        for (int unsigned n = 1; n < 3000; n++) begin
            @(negedge clk);
            start = 1'b0;
            cv = '0;
            if (n >= 2) begin
                j   = (n - 2) / period;
                off = (n - 2) - j * period;
                for (int c = 0; c < N_CH; c++)
                    if (j < nwin && off >= 3 && off < 3 + 2 * pulses[j][c] && ((off - 3) % 2) == 0)
                        cv[c] = 1'b1;
            end
            count = cv;
            if (stop_step) begin
                exp_n = 2 + win_cycles + seen * period;
                check({tag, "_stop_pos"}, n, exp_n);
                model_window(int'(seen));
                check_exports(tag);
                seen++;
                if (seen == nwin) break;
            end
        end
        check({tag, "_windows"}, seen, nwin);
        count = '0;
        if (!cont) begin
            @(negedge clk);
            check({tag, "_stop_1cyc"}, {31'h0, stop_step}, 32'h0);
            check({tag, "_idle"}, {31'h0, busy}, 32'h0);
        end
    endtask

    initial begin
        int unsigned seen_stop;
        reset = 1'b1; addr = '0; data = '0; write = 1'b0; write32 = 1'b0;
        data32 = '0; count = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sig", signals_export, 32'h0);
        check("rst_ovf", {28'h0, ovf}, 32'h0);
        check("rst_time", time_export, 32'h0);
        check("rst_stop", {30'h0, stop_step, busy}, 32'h0);
        @(negedge clk); reset = 1'b0;
        rd(BASE, "rst_ctrl", 8'h00);
        rd(BASE + 8'd1, "rst_mask", 8'h0F);
        rd(BASE + 8'd2, "rst_win", 8'h01);
        rd(8'h10, "outside", 8'h00);
        wr32(BASE + 8'd2, 32'd0);
        rd(BASE + 8'd2, "win_zero", 8'h01);

        // single-shot, window 3
        model_mask = 4'hF; model_win = 3;
        wr32(BASE + 8'd2, 32'd3);
        pulses[0] = '{7, 0, 2, 0};
        run(1, 1'b0, "single");

        // saturation on ch1
        model_win = 70;
        wr32(BASE + 8'd2, 32'd70);
        pulses[0] = '{0, 300, 0, 0};
        run(1, 1'b0, "sat");

        // enable mask
        model_win = 3; model_mask = 4'b0101;
        wr32(BASE + 8'd2, 32'd3);
        wr8(BASE + 8'd1, 8'h05);
        rd(BASE + 8'd1, "mask_rd", 8'h05);
        pulses[0] = '{3, 4, 5, 6};
        run(1, 1'b0, "mask");

        // continuous mode, three windows
        model_mask = 4'hF; model_win = 2;
        wr8(BASE + 8'd1, 8'h0F);
        wr32(BASE + 8'd2, 32'd2);
        wr8(BASE, 8'h01);
        rd(BASE, "mode_rd", 8'h01);
        for (int w = 0; w < 3; w++) begin
            pulses[w][0] = 5 + w;
            for (int c = 1; c < N_CH; c++) pulses[w][c] = int'($urandom_range(0, 8));
        end
        run(3, 1'b1, "cont");
        wr8(BASE, 8'h04);
        check("cont_abort_busy", {31'h0, busy}, 32'h0);
        check_exports("cont_hold");

        // abort mid-window leaves previous exports untouched
        model_win = 5;
        wr32(BASE + 8'd2, 32'd5);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); count = (i % 2 == 0) ? 4'hF : 4'h0;
        end
        count = '0;
        wr8(BASE, 8'h04);
        check("abort_busy", {31'h0, busy}, 32'h0);
        seen_stop = 0;
        repeat (70) begin
            @(negedge clk);
            if (stop_step) seen_stop++;
        end
        check("abort_no_stop", seen_stop, 32'h0);
        check_exports("abort_hold");

        // randomised single-shot windows
        for (int r = 0; r < 4; r++) begin
            model_win  = $urandom_range(2, 4);
            model_mask = 4'($urandom_range(0, 15));
            wr32(BASE + 8'd2, model_win);
            wr8(BASE + 8'd1, {4'h0, model_mask});
            for (int c = 0; c < N_CH; c++)
                pulses[0][c] = int'($urandom_range(0, (model_win * TICK - 4) / 2));
            run(1, 1'b0, "rand");
        end

        // reset mid-COUNT
        wr8(BASE + 8'd1, 8'h03);
        wr32(BASE + 8'd2, 32'd4);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_sig", signals_export, 32'h0);
        check("mid_rst_ovf", {28'h0, ovf}, 32'h0);
        check("mid_rst_time", time_export, 32'h0);
        check("mid_rst_flags", {30'h0, stop_step, busy}, 32'h0);
        reset = 1'b0;
        rd(BASE + 8'd1, "mid_rst_mask", 8'h0F);
        rd(BASE + 8'd2, "mid_rst_win", 8'h01);
        rd(BASE, "mid_rst_ctrl", 8'h00);
        model_win = 1; model_mask = 4'hF;
        pulses[0] = '{0, 0, 0, 1};
        run(1, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
